id_ex_stage: RTL and testbench

ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the single-cycle control decoder: it captures the decoder's control bundle plus ID-stage operands and presents them to EX. It also owns load-use hazard detection and the multi-cycle MULTU hold, and drives the PC/IF-ID write enables.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// decode constants and the MULTU hold FSM states.
package pipe_pkg;

  localparam int CTRL_W = 11;

  // Bit positions inside the control bundle
  // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,JAL,ALUOp[1:0]}
  localparam int CTRL_REGDST   = 10;
  localparam int CTRL_ALUSRC   = 9;
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_JUMP     = 3;
  localparam int CTRL_JAL      = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  // Wide enough to hold MUL_LAT-1 for the full legal range 1..16
  localparam int CNT_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination (rt) is read as a
// source by the instruction currently in ID forces a one-cycle stall.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic       id_valid_i,
  input  logic       id_jump_i,
  input  logic       id_alusrc_i,
  input  logic       id_memwrite_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       load_use_o
);

  logic uses_rs;
  logic uses_rt;

  // Source usage of the ID instruction and the resulting hazard
  always_comb begin
    uses_rs    = ~id_jump_i;
    // Stores read rt as the data to be written even though ALUSrc is set
    uses_rt    = (~id_alusrc_i & ~id_jump_i) | id_memwrite_i;
    load_use_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != 5'd0) & id_valid_i &
                 ((uses_rs & (ex_rt_i == id_rs_i)) | (uses_rt & (ex_rt_i == id_rt_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and multi-cycle MULTU hold.
// Drives the PC and IF/ID write enables for the upstream stages.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DW      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DW-1:0]     id_rd1,
  input  logic [DW-1:0]     id_rd2,
  input  logic [DW-1:0]     id_imm,
  input  logic [DW-1:0]     id_pc4,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DW-1:0]     ex_rd1,
  output logic [DW-1:0]     ex_rd2,
  output logic [DW-1:0]     ex_imm,
  output logic [DW-1:0]     ex_pc4,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              mul_busy
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [5:0]        funct_q, funct_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DW-1:0]     rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;

  logic load_use;
  logic id_is_mul;
  logic stall;

  hazard_detect u_hazard (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i       (rt_q),
    .id_valid_i    (id_valid),
    .id_jump_i     (id_ctrl[CTRL_JUMP]),
    .id_alusrc_i   (id_ctrl[CTRL_ALUSRC]),
    .id_memwrite_i (id_ctrl[CTRL_MEMWRITE]),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .load_use_o    (load_use)
  );

  // Upstream enables; a flush redirects IF, so it must never be frozen then
  always_comb begin
    id_is_mul  = id_valid & (id_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO] == ALUOP_RTYPE) &
                 (id_funct == FUNCT_MULTU);
    stall      = load_use | (state_q == MUL_BUSY);
    pc_write   = ~stall | flush;
    ifid_write = ~stall | flush;
    mul_busy   = (state_q == MUL_BUSY);
  end

  // Next-state: flush > MULTU hold > load-use bubble > empty-ID bubble > load
  always_comb begin
    // NOTE: every signal gets a default first (hold) so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    funct_d = funct_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;

    if (flush || state_q == RUN) begin
      // Every non-hold case captures the ID data; bubbles only clear control
      funct_d = id_funct;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      pc4_d   = id_pc4;
      valid_d = 1'b0;
      ctrl_d  = '0;
    end

    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == MUL_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = RUN;
      end
    end else if (!load_use && id_valid) begin
      valid_d = 1'b1;
      ctrl_d  = id_ctrl;
      if (id_is_mul && MUL_LAT > 1) begin
        state_d = MUL_BUSY;
        cnt_d   = CNT_W'(MUL_LAT - 1);
      end
    end
  end

  // State and pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      funct_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      funct_q <= funct_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_ctrl  = ctrl_q;
  assign ex_funct = funct_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_pc4   = pc4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a cycle-level reference model pushes the
// expected outputs per cycle; a negedge monitor pops and compares.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int DW      = 32;
  localparam int MUL_LAT = 4;

  // Typical decoder bundles
  localparam logic [10:0] C_LW    = 11'h3C0;
  localparam logic [10:0] C_RTYPE = 11'h482;
  localparam logic [10:0] C_MULTU = 11'h402;
  localparam logic [10:0] C_ADDIU = 11'h280;
  localparam logic [10:0] C_SW    = 11'h220;
  localparam logic [10:0] C_J     = 11'h008;
  localparam logic [5:0]  F_ADD   = 6'b100000;

  logic          clk, rst, id_valid, flush;
  logic [10:0]   id_ctrl;
  logic [5:0]    id_funct;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
  logic          ex_valid, pc_write, ifid_write, mul_busy;
  logic [10:0]   ex_ctrl;
  logic [5:0]    ex_funct;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;

  id_ex_stage #(.MUL_LAT(MUL_LAT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
    .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .pc_write(pc_write),
    .ifid_write(ifid_write), .mul_busy(mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pcw, ifw, busy, valid;
    bit [10:0]   ctrl;
    bit [5:0]    funct;
    bit [4:0]    rs, rt, rd;
    bit [DW-1:0] rd1, rd2, imm, pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what EX holds, plus how many more cycles it stays frozen
  bit          m_valid;
  bit [10:0]   m_ctrl;
  bit [5:0]    m_funct;
  bit [4:0]    m_rs, m_rt, m_rd;
  bit [DW-1:0] m_rd1, m_rd2, m_imm, m_pc4;
  int          m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    bit rs_src, rt_src;
    rs_src = !id_ctrl[3];
    rt_src = (!id_ctrl[9] && !id_ctrl[3]) || id_ctrl[5];
    return m_valid && m_ctrl[6] && m_rt != 0 && id_valid &&
           ((rs_src && m_rt == id_rs) || (rt_src && m_rt == id_rt));
  endfunction

  task automatic push_expect();
    exp_t e;
    bit   frozen;
    frozen  = model_load_use() || (m_hold > 0);
    e.pcw   = !frozen || flush;
    e.ifw   = !frozen || flush;
    e.busy  = (m_hold > 0);
    e.valid = m_valid;  e.ctrl = m_ctrl;  e.funct = m_funct;
    e.rs    = m_rs;     e.rt   = m_rt;    e.rd    = m_rd;
    e.rd1   = m_rd1;    e.rd2  = m_rd2;   e.imm   = m_imm;  e.pc4 = m_pc4;
    exp_q.push_back(e);
  endtask

  task automatic capture_id(input bit real_instr);
    m_valid = real_instr;
    m_ctrl  = real_instr ? id_ctrl : 11'd0;
    m_funct = id_funct; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_pc4 = id_pc4;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_clock();
    bit lu;
    lu = model_load_use();
    if (!rst) begin
      m_valid = 0; m_ctrl = 0; m_funct = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc4 = 0; m_hold = 0;
    end else if (flush) begin
      capture_id(1'b0);
      m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (lu || !id_valid) begin
      capture_id(1'b0);
    end else begin
      capture_id(1'b1);
      if (id_ctrl[1:0] == 2'b10 && id_funct == 6'b011001 && MUL_LAT > 1)
        m_hold = MUL_LAT - 1;
    end
  endtask

  task automatic set_inputs(input bit r, input bit v, input logic [10:0] c,
                            input logic [5:0] f, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d, input bit fl);
    rst = r; id_valid = v; id_ctrl = c; id_funct = f;
    id_rs = s; id_rt = t; id_rd = d; flush = fl;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
  endtask

  // One cycle: drive, record expectation, take the edge, update the model
  task automatic issue(input bit r, input bit v, input logic [10:0] c,
                       input logic [5:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input bit fl);
    set_inputs(r, v, c, f, s, t, d, fl);
    push_expect();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_write",   32'(pc_write),   32'(e.pcw));
      check("ifid_write", 32'(ifid_write), 32'(e.ifw));
      check("mul_busy",   32'(mul_busy),   32'(e.busy));
      check("ex_valid",   32'(ex_valid),   32'(e.valid));
      check("ex_ctrl",    32'(ex_ctrl),    32'(e.ctrl));
      check("ex_funct",   32'(ex_funct),   32'(e.funct));
      check("ex_rs",      32'(ex_rs),      32'(e.rs));
      check("ex_rt",      32'(ex_rt),      32'(e.rt));
      check("ex_rd",      32'(ex_rd),      32'(e.rd));
      check("ex_rd1",     ex_rd1,          e.rd1);
      check("ex_rd2",     ex_rd2,          e.rd2);
      check("ex_imm",     ex_imm,          e.imm);
      check("ex_pc4",     ex_pc4,          e.pc4);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] c;
    logic [5:0]  f;
    int          kind;
    // Reset: two cycles with a real instruction presented
    set_inputs(0, 1, C_LW, 6'd0, 5'd1, 5'd2, 5'd0, 0);
    @(posedge clk);
    model_clock();
    #1;
    issue(0, 1, C_LW, 6'd0, 5'd1, 5'd2, 5'd0, 0);

    // Load-use: LW $8 then ADD $9,$8,$10 (held in ID for the stall cycle)
    issue(1, 1, C_LW,    6'd0,  5'd1,  5'd8,  5'd0, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd8,  5'd10, 5'd9, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd8,  5'd10, 5'd9, 0);
    // LW $0 then a consumer of $0: no stall
    issue(1, 1, C_LW,    6'd0,  5'd1,  5'd0,  5'd0, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd0,  5'd0,  5'd9, 0);
    // LW $8 then ADDIU $8,$10,5: rt is a destination, no stall
    issue(1, 1, C_LW,    6'd0,  5'd1,  5'd8,  5'd0, 0);
    issue(1, 1, C_ADDIU, 6'd0,  5'd10, 5'd8,  5'd0, 0);
    // LW $8 then SW $8: store data is a source
    issue(1, 1, C_LW,    6'd0,  5'd1,  5'd8,  5'd0, 0);
    issue(1, 1, C_SW,    6'd0,  5'd3,  5'd8,  5'd0, 0);
    issue(1, 1, C_SW,    6'd0,  5'd3,  5'd8,  5'd0, 0);

    // MULTU: EX held MUL_LAT cycles, upstream frozen MUL_LAT-1
    issue(1, 1, C_MULTU, FUNCT_MULTU, 5'd4, 5'd5, 5'd0, 0);
    for (int i = 0; i < MUL_LAT; i++) issue(1, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 0);

    // Flush in the second busy cycle
    issue(1, 1, C_MULTU, FUNCT_MULTU, 5'd4, 5'd5, 5'd0, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 1);
    issue(1, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 0);

    // Flush together with a load-use
    issue(1, 1, C_LW,    6'd0,  5'd1, 5'd5, 5'd0, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd5, 5'd2, 5'd3, 1);
    issue(1, 1, C_J,     6'd0,  5'd5, 5'd5, 5'd0, 0);

    // Empty ID slot carrying all-ones control
    issue(1, 0, 11'h7FF, 6'h3F, 5'd7, 5'd7, 5'd7, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd1, 5'd2, 5'd3, 0);

    // Reset in the middle of a MULTU hold
    issue(1, 1, C_MULTU, FUNCT_MULTU, 5'd4, 5'd5, 5'd0, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 0);
    issue(0, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 0);
    issue(1, 1, C_RTYPE, F_ADD, 5'd6, 5'd7, 5'd11, 0);

    // Random traffic over a small register set so hazards are frequent
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 7);
      f    = F_ADD;
      case (kind)
        0, 1: c = C_LW;
        2:    c = C_RTYPE;
        3:    c = C_ADDIU;
        4:    c = C_SW;
        5:    c = C_J;
        6:    begin c = C_MULTU; f = FUNCT_MULTU; end
        default: begin c = 11'($urandom); f = 6'($urandom); end
      endcase
      issue($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, c, f,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
